// File: rtl/w_ram_pkg.sv
// rtl/w_ram_pkg.sv - shared constants and reader state enum for the w RAM reader
package w_ram_pkg;

    localparam int W_DATA_WIDTH = 8;
    localparam int W_ADDR_WIDTH = 7;
    localparam int W_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

endpackage

// File: rtl/w_reader_skid_fifo.sv
// rtl/w_reader_skid_fifo.sv - two-entry FIFO absorbing RAM read latency under backpressure
module w_reader_skid_fifo #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  push_en;
    logic                  pop_en;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign pop_en  = pop && !empty;
    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign data    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_en) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/w_value_reader.sv
// rtl/w_value_reader.sv - bursts w values from a synchronous RAM into a ready/valid stream
// Optional stall counter enabled by defining W_READER_STALL_CNT_EN.
module w_value_reader
    import w_ram_pkg::*;
#(
    parameter int DATA_WIDTH = W_DATA_WIDTH,
    parameter int ADDR_WIDTH = W_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [15:0]           stall_cnt
);

    localparam int LEN_WIDTH = ADDR_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;

    reader_state_t          state;
    reader_state_t          state_nxt;
    logic [LEN_WIDTH-1:0]   issue_left;
    logic [LEN_WIDTH-1:0]   beats_left;
    logic                   in_flight;
    logic                   issue;
    logic                   start_ok;
    logic                   pop;
    logic [2:0]             credit;
    logic [1:0]             fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_last  = out_valid && (beats_left == LEN_ONE);
    assign busy      = (state != IDLE);
    assign done      = (state == DRAIN) && (beats_left == LEN_ZERO);

    // Words already buffered or arriving next cycle, less the one leaving now.
    assign credit = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        start_ok  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = (len == LEN_ZERO) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if ((credit < 3'd2) && !(fifo_full && !pop)) begin
                    issue = 1'b1;
                    if (issue_left == LEN_ONE) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beats_left == LEN_ZERO) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            issue_left <= '0;
            beats_left <= '0;
            in_flight  <= 1'b0;
            read_addr  <= '0;
        end else begin
            state     <= state_nxt;
            in_flight <= issue;
            if (start_ok) begin
                issue_left <= len;
                beats_left <= len;
                read_addr  <= base_addr;
            end else begin
                if (issue) begin
                    issue_left <= issue_left - LEN_ONE;
                    // Keep the final address on the bus rather than running past the burst.
                    if (issue_left != LEN_ONE) begin
                        read_addr <= read_addr + ADDR_WIDTH'(1);
                    end
                end
                if (pop) begin
                    beats_left <= beats_left - LEN_ONE;
                end
            end
        end
    end

    w_reader_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_flight),
        .push_data (q),
        .pop       (pop),
        .data      (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef W_READER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else if (start_ok) begin
            stall_q <= 16'd0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_w_value_reader.sv
// tb/tb_w_value_reader.sv - directed self-checking bench for w_value_reader
module tb_w_value_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  base_addr;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic [6:0]  read_addr;
    logic [7:0]  q;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] stall_cnt;

    logic [7:0]  mem [128];

    int n_checks;
    int n_pass;
    int res_addr1;
    int res_busy0;
    int res_busy1;
    int res_first_valid;
    int res_done;

    w_value_reader #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .read_addr (read_addr),
        .q         (q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) q <= mem[read_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int c);
        if (mode == 1) return (c % 3) == 0;
        return 1'b1;
    endfunction

    task automatic run_burst(input int base, input int len_v, input int mode, input bit hold);
        int   c;
        int   nbeats;
        int   stalls;
        int   max_cnt;
        bit   prev_stall;
        bit   got_done;
        logic [7:0] prev_data;
        c = 0; nbeats = 0; stalls = 0; max_cnt = 0;
        prev_stall = 0; got_done = 0; prev_data = '0;
        res_first_valid = -1; res_done = -1; res_addr1 = -1;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 7'(base); len = 8'(len_v); out_ready = rdy(mode, 0);
        while (!got_done && c < 2000) begin
            @(negedge clk);
            if (c == 0) res_busy0 = int'(busy);
            if (c == 1) begin res_busy1 = int'(busy); res_addr1 = int'(read_addr); end
            if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid) begin
                if (res_first_valid < 0) res_first_valid = c;
                if (out_ready) begin
                    check("beat_data", 32'(out_data), 32'((base + nbeats) % 128));
                    check("beat_last", 32'(out_last), 32'(nbeats == len_v - 1));
                    nbeats++;
                end else begin
                    stalls++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin got_done = 1; res_done = c; end
            @(posedge clk); #1;
            c++;
            start = hold && !got_done;
            if (hold) begin base_addr = 7'd50; len = 8'd3; end
            out_ready = rdy(mode, c);
        end
        if (!got_done) check("done_timeout", 32'd0, 32'd1);
        check("beat_count", 32'(nbeats), 32'(len_v));
        check("fifo_max", 32'(max_cnt <= 2), 32'd1);
`ifdef W_READER_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(stalls));
`else
        check("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(negedge clk);
        check("done_once", 32'(done), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int dcount;
        n_checks = 0; n_pass = 0;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr", 32'(read_addr), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        run_burst(0, 4, 0, 0);
        check("lat_busy0", 32'(res_busy0), 32'd0);
        check("lat_busy1", 32'(res_busy1), 32'd1);
        check("lat_addr1", 32'(res_addr1), 32'd0);
        check("lat_first_valid", 32'(res_first_valid), 32'd3);
        check("lat_done", 32'(res_done), 32'd7);

        run_burst(126, 4, 0, 0);
        run_burst(20, 8, 1, 0);

        run_burst(33, 0, 0, 0);
        check("len0_no_valid", 32'(res_first_valid), 32'hFFFF_FFFF);
        check("len0_done", 32'(res_done), 32'd1);

        run_burst(0, 128, 0, 0);

        @(posedge clk); #1;
        start = 1'b1; base_addr = 7'd0; len = 8'd8; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_addr", 32'(read_addr), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_stall", 32'(stall_cnt), 32'd0);
        dcount = 0;
        repeat (3) begin @(negedge clk); if (done) dcount++; end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (done || busy) dcount++; end
        check("mid_rst_no_done", 32'(dcount), 32'd0);
        run_burst(10, 2, 0, 0);

        run_burst(5, 6, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/w_value_reader.md
W_VALUE_READER -- requirements
Module: w_value_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, width of one w value.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 7, w RAM address width, giving 2**ADDR_WIDTH words.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, a one-cycle burst request.
REQ-006 The block SHALL have port base_addr, input, ADDR_WIDTH, the first word address, sampled with start.
REQ-007 The block SHALL have port len, input, ADDR_WIDTH+1, the word count 0..2**ADDR_WIDTH, sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse at burst completion.
REQ-010 The block SHALL have port read_addr, output, ADDR_WIDTH, driven to the w RAM read address.
REQ-011 The block SHALL have port q, input, DATA_WIDTH, w RAM read data, valid the cycle after read_addr is registered by the RAM.
REQ-012 The block SHALL have port out_data, output, DATA_WIDTH, streamed w value.
REQ-013 The block SHALL have port out_valid, output, 1, streamed word valid.
REQ-014 The block SHALL have port out_ready, input, 1, consumer accept; a beat transfers when out_valid and out_ready are both high.
REQ-015 The block SHALL have port out_last, output, 1, high on the final beat of a burst.
REQ-016 The block SHALL have port stall_cnt, output, 16, stall counter (see Configuration).

Function
REQ-017 States SHALL be IDLE, RUN and DRAIN; in IDLE, start moves to RUN, or to DRAIN if len=0.
REQ-018 start while busy SHALL be ignored, with no effect on the current burst.
REQ-019 In RUN, an issue SHALL present the next address on read_addr; addresses SHALL increment by 1 modulo 2**ADDR_WIDTH, so 127 wraps to 0.
REQ-020 An issue SHALL be permitted only when FIFO occupancy + in-flight count - pop-this-cycle < 2, so the 2-entry FIFO never overflows.
REQ-021 The in-flight flag SHALL be registered at issue; the cycle after, q SHALL be pushed into the FIFO.
REQ-022 Once all len issues are done, RUN SHALL move to DRAIN.
REQ-023 DRAIN SHALL pulse done and return to IDLE in the cycle after the last beat transfers; for len=0, done SHALL pulse the cycle after start with no beats.
REQ-024 Latency: with start in cycle 0 and out_ready high, read_addr=base_addr in cycle 1, out_valid first high in cycle 3, then one beat per cycle.
REQ-025 out_data/out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Exactly len beats SHALL be produced in address order with no loss or duplication under any out_ready pattern.
REQ-027 read_addr SHALL hold its last value when not issuing.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, empty FIFO, in-flight cleared, and busy, done, out_valid, out_last, read_addr, out_data and stall_cnt all 0.
REQ-029 Reset mid-burst SHALL abandon the burst with no done pulse; the next start after release SHALL behave as from power-up.

Configuration
REQ-030 With W_READER_STALL_CNT_EN defined, stall_cnt SHALL count cycles with out_valid=1 and out_ready=0, saturate at 0xFFFF, and clear on accepted start.
REQ-031 Without W_READER_STALL_CNT_EN, stall_cnt SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-032 Package w_ram_pkg SHALL hold the default DATA_WIDTH/ADDR_WIDTH constants and the reader state enum (IDLE, RUN, DRAIN).
REQ-033 The 2-entry FIFO SHALL be sub-module w_reader_skid_fifo (push, pop, data, count, full, empty).

Verification
REQ-034 RAM preloaded mem[i]=i; start, base=0, len=4, out_ready=1 -> read_addr=0 in cycle 1, beats 0,1,2,3 in cycles 3-6, out_last with 3, done in cycle 7.
REQ-035 Wrap test: base=126, len=4 -> beats 126,127,0,1.
REQ-036 Backpressure: len=8, out_ready toggling 1,0,0,1,... -> 8 in-order beats with stable data while stalled, FIFO never exceeding 2 entries; with macro defined, stall_cnt equals the stalled-cycle count.
REQ-037 len=0 -> no out_valid, done pulse the cycle after start; len=128 -> 128 beats covering every address once.
REQ-038 Reset and restart: rst_n low after 2 beats of a len=8 burst -> outputs 0, no done; start base=10, len=2 -> beats 10,11 and done.
REQ-039 start held high during a busy burst -> ignored; burst completes unchanged.
